seq_chunk_multiplier: RTL and testbench

Parametrised, multi-cycle unsigned multiplier that computes `p = a * b` by consuming `b` one `CHUNK`-bit digit per cycle and accumulating the shifted partial products. It terminates early once the remaining digits of `b` are zero. It replaces the fixed 32-bit combinational recursive multipliers where area matters more than latency. It uses valid/ready handshakes on both sides and can compile in the approximate low-column truncation used by the approximate multiplier family.

---
 rtl/mult_seq_pkg.sv | 30 +++
 rtl/nr_row_mul.sv | 20 ++
 rtl/seq_chunk_multiplier.sv | 126 ++++++++++++
 tb/tb_seq_chunk_multiplier.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_seq_pkg.sv
// rtl/mult_seq_pkg.sv - shared state type and elaboration helpers for seq_chunk_multiplier
package mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MASK_MAX_W = 128;

  function automatic int chunks_f(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic int cnt_w_f(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Ones everywhere except the discarded low product columns; callers slice to width.
  function automatic logic [MASK_MAX_W-1:0] trunc_mask_f(input int trunc_bits);
    logic [MASK_MAX_W-1:0] m;
    m = '1;
    for (int i = 0; i < MASK_MAX_W; i++) begin
      if (i < trunc_bits) m[i] = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/nr_row_mul.sv
// rtl/nr_row_mul.sv - combinational WIDTH x CHUNK unsigned row multiplier
module nr_row_mul #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic [WIDTH-1:0]       a,
  input  logic [CHUNK-1:0]       d,
  output logic [WIDTH+CHUNK-1:0] row
);

  localparam int RW = WIDTH + CHUNK;

  always_comb begin
    row = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (d[i]) row = row + (RW'(a) << i);
    end
  end

endmodule

// File: rtl/seq_chunk_multiplier.sv
// rtl/seq_chunk_multiplier.sv - digit-serial unsigned multiplier with early exit
// Define MULT_APPROX_TRUNC_EN to zero the low TRUNC_BITS columns of every partial product.
module seq_chunk_multiplier
  import mult_seq_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 8,
  parameter int TRUNC_BITS = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int N     = chunks_f(WIDTH, CHUNK);
  localparam int CNT_W = cnt_w_f(N);
  localparam int PW    = 2 * WIDTH;
  localparam int RW    = WIDTH + CHUNK;

  if (WIDTH % CHUNK != 0) begin : g_chunk_check
    $error("seq_chunk_multiplier: CHUNK must divide WIDTH");
  end
  if (TRUNC_BITS >= PW) begin : g_trunc_check
    $error("seq_chunk_multiplier: TRUNC_BITS must be below 2*WIDTH");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_rem_q, b_rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    acc_q, acc_d;

  logic [RW-1:0]    row;
  logic [PW-1:0]    part;
  logic [WIDTH-1:0] b_shift;
  logic             accept;

  nr_row_mul #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) u_row (
    .a  (a_q),
    .d  (b_rem_q[CHUNK-1:0]),
    .row(row)
  );

`ifdef MULT_APPROX_TRUNC_EN
  localparam logic [PW-1:0] TRUNC_MASK = PW'(trunc_mask_f(TRUNC_BITS));
`endif

  always_comb begin
    part = PW'(row) << (32'(cnt_q) * 32'(CHUNK));
`ifdef MULT_APPROX_TRUNC_EN
    part = part & TRUNC_MASK;
`endif
    b_shift = b_rem_q >> CHUNK;
  end

  // out_ready feeds in_ready combinationally so DONE can overlap the next accept.
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC);
  assign p         = acc_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_rem_d = b_rem_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = CALC;
          a_d     = a;
          b_rem_d = b;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      CALC: begin
        acc_d   = acc_q + part;
        b_rem_d = b_shift;
        cnt_d   = cnt_q + CNT_W'(1);
        if (b_shift == '0) state_d = DONE;
      end
      DONE: begin
        if (accept) begin
          state_d = CALC;
          a_d     = a;
          b_rem_d = b;
          cnt_d   = '0;
          acc_d   = '0;
        end else if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_rem_q <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_rem_q <= b_rem_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_seq_chunk_multiplier.sv
// tb/tb_seq_chunk_multiplier.sv - self-checking bench for seq_chunk_multiplier
`timescale 1ns/1ps
module tb_seq_chunk_multiplier;

  localparam int W  = 32;
  localparam int C  = 8;
  localparam int T  = 5;
  localparam int N  = W / C;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0]  a, b;
  logic [PW-1:0] p;

  int n_chk  = 0;
  int n_fail = 0;

  seq_chunk_multiplier #(
    .WIDTH(W), .CHUNK(C), .TRUNC_BITS(T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int k_of(input logic [W-1:0] bv);
    int bl;
    bl = 0;
    for (int i = 0; i < W; i++) if (bv[i]) bl = i + 1;
    return (bl == 0) ? 1 : (bl + C - 1) / C;
  endfunction

  // Transaction-level model: 0 idle, 1 computing (k cycles), 2 holding the result.
  int            m_phase = 0;
  int            m_left  = 0;
  logic [PW-1:0] m_p     = '0;
  bit            m_p_zero = 1'b1;
  bit            m_seen_rst = 1'b0;
  int            n_acc = 0;
  bit            m_rdy, m_take;

  always @(posedge clk) begin
    m_rdy  = (m_phase == 0) || ((m_phase == 2) && (out_ready === 1'b1));
    m_take = (in_valid === 1'b1) && m_rdy;
    if (rst_n !== 1'b1) begin
      m_phase    = 0;
      m_p_zero   = 1'b1;
      m_seen_rst = 1'b1;
    end else begin
      if (m_phase == 1) begin
        m_left--;
        if (m_left == 0) m_phase = 2;
      end else if ((m_phase == 2) && (out_ready === 1'b1)) begin
        m_phase = 0;
      end
      if (m_take) begin
        m_phase  = 1;
        m_left   = k_of(b);
        m_p      = PW'(a) * PW'(b);
        m_p_zero = 1'b0;
        n_acc++;
      end
    end
  end

  always @(negedge clk) begin
    if (m_seen_rst) begin
      chk("in_ready", in_ready, (m_phase == 0) || ((m_phase == 2) && out_ready));
      chk("out_valid", out_valid, m_phase == 2);
      chk("busy", busy, m_phase == 1);
      if (m_phase == 2) begin
`ifdef MULT_APPROX_TRUNC_EN
        chk("p_low_cols", p[T-1:0], 0);
        chk("p_err_bound", (p <= m_p) && ((m_p - p) < (PW'(N) << T)), 1);
`else
        chk("p", p, m_p);
`endif
      end else if (m_p_zero) begin
        chk("p_after_reset", p, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        output int lat, output logic [PW-1:0] pv);
    int g;
    g = 0;
    a = av;
    b = bv;
    in_valid = 1'b1;
    while (!in_ready && g < 50) begin
      tick();
      g++;
    end
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    pv = p;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int            lat;
    int            target;
    logic [PW-1:0] pv;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_p", p, 0);
    chk("rst_busy", busy, 0);

    chk("model_k_ff", k_of(32'h0000_00FF), 1);
    chk("model_k_10000", k_of(32'h0001_0000), 3);
    chk("model_k_msb", k_of(32'h8000_0000), 4);
    chk("model_k_zero", k_of(32'h0), 1);

    out_ready = 1'b1;
    run_op(32'hFFFF_FFFF, 32'h0000_00FF, lat, pv);
    chk("early_lat", lat, 1);
    chk("early_model_p", m_p, 64'h0000_00FE_FFFF_FF01);
`ifndef MULT_APPROX_TRUNC_EN
    chk("early_p", pv, 64'h0000_00FE_FFFF_FF01);
`endif

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, pv);
    chk("full_lat", lat, 4);
`ifdef MULT_APPROX_TRUNC_EN
    chk("full_p_low", pv[T-1:0], 0);
    chk("full_p_err", (64'hFFFF_FFFE_0000_0001 - pv) < 128, 1);
`else
    chk("full_p", pv, 64'hFFFF_FFFE_0000_0001);
`endif

    tick();
    out_ready = 1'b0;
    run_op(32'd7, 32'd9, lat, pv);
    chk("bp_lat", lat, 1);
    for (int i = 0; i < 3; i++) begin
`ifndef MULT_APPROX_TRUNC_EN
      chk("bp_p_hold", p, 63);
`endif
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      tick();
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = 32'd3;
    b = 32'd5;
    #1;
    chk("b2b_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("b2b_busy", busy, 1);
    tick();
    chk("b2b_out_valid", out_valid, 1);
`ifndef MULT_APPROX_TRUNC_EN
    chk("b2b_p", p, 15);
`endif

    tick();
    a = $urandom;
    b = 32'h8000_0000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_p", p, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_valid", out_valid, 0);
    end

    target = n_acc + 3000;
    for (int cyc = 0; cyc < 60000 && n_acc < target; cyc++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      a         = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
      b         = W'($urandom) >> $urandom_range(0, 32);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    chk("random_ops_done", n_acc >= target, 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
